// File: rtl/neuron_mac_unit.sv
// neuron_mac_unit: sequential multiply-accumulate neuron.
//   Loads a signed bias on start, accumulates N_IN signed x*w products received over a
//   valid/ready stream, then shifts right arithmetically, saturates to DW bits and presents
//   the result with a valid/ready handshake.
// Optional feature macro: NEURON_RELU_EN (negative shifted sums produce y = 0).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, bias           begin an evaluation (IDLE only), bias preloaded into the accumulator
//   in_valid, in_ready    x/w pair handshake; x, w signed operands
//   out_valid, out_ready  result handshake; y saturated activation, acc_out raw accumulator
//   busy                  evaluation in progress (state != IDLE)
module neuron_mac_unit #(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 21,
  parameter int unsigned N_IN  = 32,
  parameter int unsigned SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    x,
  input  logic signed [DW-1:0]    w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    y,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    busy
);

  localparam int unsigned CntW = $clog2(N_IN + 1);

  localparam logic signed [ACC_W-1:0] SatMax = ACC_W'((1 << (DW - 1)) - 1);
`ifdef NEURON_RELU_EN
  localparam logic signed [ACC_W-1:0] SatMin = '0;
`else
  localparam logic signed [ACC_W-1:0] SatMin = ACC_W'(-(1 << (DW - 1)));
`endif

  typedef enum logic [1:0] {StIdle, StAcc, StAct, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic signed [DW-1:0]    y_q, y_d;

  logic                    beat;
  logic                    last_beat;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] shifted;
  logic signed [DW-1:0]    y_sat;

  assign beat      = in_valid & in_ready;
  assign last_beat = beat && (cnt_q == CntW'(N_IN - 1));
  assign prod      = x * w;
  assign shifted   = acc_q >>> SHIFT;

  always_comb begin
    if (shifted > SatMax) begin
      y_sat = SatMax[DW-1:0];
    end else if (shifted < SatMin) begin
      y_sat = SatMin[DW-1:0];
    end else begin
      y_sat = shifted[DW-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start)     state_d = StAcc;
      StAcc:  if (last_beat) state_d = StAct;
      StAct:                 state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready  = (state_q == StAcc);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  // Datapath next state
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    acc_out_d = acc_out_q;
    if (state_q == StIdle && start) begin
      acc_d = bias;
      cnt_d = '0;
    end
    if (beat) begin
      // Sign-extend the product; the sum wraps modulo 2^ACC_W.
      acc_d = acc_q + ACC_W'(prod);
      cnt_d = cnt_q + CntW'(1);
    end
    if (state_q == StAct) begin
      y_d       = y_sat;
      acc_out_d = acc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      acc_out_q <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      acc_out_q <= acc_out_d;
    end
  end

  assign y       = y_q;
  assign acc_out = acc_out_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
module tb_neuron_mac_unit;

  localparam int DW    = 8;
  localparam int ACC_W = 21;
  localparam int N_IN  = 32;
  localparam int SHIFT = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic signed [ACC_W-1:0] bias = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [DW-1:0]    x = '0;
  logic signed [DW-1:0]    w = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [DW-1:0]    y;
  logic signed [ACC_W-1:0] acc_out;
  logic                    busy;

  typedef struct {
    logic signed [ACC_W-1:0] acc;
    logic [DW-1:0]           y;
  } result_t;

  result_t sb[$];
  int errors = 0;
  int checks = 0;

  neuron_mac_unit #(
    .DW   (DW),
    .ACC_W(ACC_W),
    .N_IN (N_IN),
    .SHIFT(SHIFT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .w        (w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .acc_out  (acc_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model_y(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
`ifdef NEURON_RELU_EN
    if (s < 0) return 8'h00;
`else
    if (s < -128) return 8'h80;
`endif
    if (s > 127) return 8'h7f;
    return s[DW-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (y !== 8'sd0) begin errors++; $display("FAIL reset_y: got %h want 00", y); end
    checks++; if (acc_out !== 21'sd0) begin errors++; $display("FAIL reset_acc: got %0d want 0", acc_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ir: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ir: got %b want 0", in_ready); end
  endtask

  // One full evaluation: start, N_IN beats (optional gaps / random operands), result check,
  // optional hold phase with out_ready low while start and in_valid are pulsed.
  task automatic run_eval(input logic signed [ACC_W-1:0] b, input logic signed [DW-1:0] xv,
                          input logic signed [DW-1:0] wv, input bit gaps, input int hold,
                          input bit rnd, input string name);
    logic signed [ACC_W-1:0] am;
    logic signed [DW-1:0]    xi, wi;
    logic signed [2*DW-1:0]  p;
    result_t                 e;
    int                      n;
    am = b;
    bias = b;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1", name, busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ir: got %b want 1", name, in_ready); end
    for (int i = 0; i < N_IN; i++) begin
      if (gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        x = 8'sd85;
        w = 8'sd85;
        step();
        step();
      end
      xi = rnd ? DW'($urandom) : xv;
      wi = rnd ? DW'($urandom) : wv;
      in_valid = 1'b1;
      x = xi;
      w = wi;
      p = xi * wi;
      am = am + ACC_W'(p);
      step();
    end
    in_valid = 1'b0;
    sb.push_back('{acc: am, y: model_y(am)});
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_lat_act: out_valid=%b want 0", name, out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_lat_done: out_valid=%b want 1", name, out_valid); end
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    if (out_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: out_valid=%b want 1 within 10 cycles", name, out_valid);
      return;
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb: got output with 0 entries want 1", name);
      return;
    end
    e = sb.pop_front();
    checks++; if (acc_out !== e.acc) begin errors++; $display("FAIL %s_acc: got %0d want %0d", name, acc_out, e.acc); end
    checks++; if (y !== e.y) begin errors++; $display("FAIL %s_y: got %h want %h", name, y, e.y); end
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = 1'b1;
      in_valid = 1'b1;
      x = 8'sd7;
      w = 8'sd9;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_hold_ov: got %b want 1", name, out_valid); end
      checks++; if (y !== e.y) begin errors++; $display("FAIL %s_hold_y: got %h want %h", name, y, e.y); end
      checks++; if (acc_out !== e.acc) begin errors++; $display("FAIL %s_hold_acc: got %0d want %0d", name, acc_out, e.acc); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_hold_ir: got %b want 0", name, in_ready); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_release_ov: got %b want 0", name, out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_release_busy: got %b want 0", name, busy); end
    checks++; if (y !== e.y) begin errors++; $display("FAIL %s_keep_y: got %h want %h", name, y, e.y); end
    step();
  endtask

  task automatic test_basic();
    run_eval(21'sd0, 8'sd1, 8'sd1, 1'b0, 0, 1'b0, "ones");
  endtask

  task automatic test_saturation();
    run_eval(21'sd0, 8'sd127, 8'sd127, 1'b0, 0, 1'b0, "sat_hi");
    run_eval(21'sd0, -8'sd128, 8'sd127, 1'b0, 0, 1'b0, "sat_lo");
  endtask

  task automatic test_hold();
    run_eval(21'sd100, 8'sd3, -8'sd5, 1'b0, 5, 1'b0, "hold");
  endtask

  task automatic test_gaps();
    run_eval(-21'sd16, 8'sd1, 8'sd1, 1'b1, 0, 1'b0, "gaps");
  endtask

  task automatic test_random();
    run_eval(21'sd1234, 8'sd0, 8'sd0, 1'b1, 0, 1'b1, "rand0");
    run_eval(-21'sd777, 8'sd0, 8'sd0, 1'b0, 0, 1'b1, "rand1");
  endtask

  task automatic test_reset_mid();
    bias = 21'sd5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      x = 8'sd3;
      w = 8'sd3;
      step();
    end
    #2 rst = 1'b1;
    #1;
    in_valid = 1'b0;
    checks++; if (y !== 8'sd0) begin errors++; $display("FAIL rstmid_y: got %h want 00", y); end
    checks++; if (acc_out !== 21'sd0) begin errors++; $display("FAIL rstmid_acc: got %0d want 0", acc_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ov: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ir: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    step();
    rst = 1'b0;
    step();
    run_eval(21'sd0, 8'sd2, 8'sd3, 1'b0, 0, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_hold();
    test_gaps();
    test_random();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
